// File: rtl/ysyx_041461_mem_lsu.sv
// ysyx_041461_mem_lsu
// MEM-stage load/store unit. Takes the MEM pipeline register contents and
// drives one data-memory access at a time over a valid/ready request bus
// with a valid-only response. Holds the pipeline through lsu_stall until the
// access completes, then returns extended load data with a one-cycle
// lsu_done pulse.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   lsu_valid_in     MEM register holds a valid instruction
//   lsu_ctrl_in[3:0] access kind (LB..LD, LBU..LWU, SB..SD, others NOP)
//   lsu_addr_in      effective byte address
//   lsu_wdata_in     store data, low bytes significant
//   lsu_flush        kill the current access
//   mem_req_*        request channel (valid/ready, doubleword address,
//                    write enable, lane-shifted strobes and data)
//   mem_rsp_*        response channel (valid, aligned 64-bit read data)
//   lsu_stall        hold the upstream pipeline register
//   lsu_done         one-cycle completion pulse
//   lsu_rdata        extended load result, valid with lsu_done
//   lsu_trap         00 none, 01 misaligned, 10 access fault, valid with lsu_done
//
// state  | meaning
// S_IDLE | no access in flight; decode the MEM register contents
// S_REQ  | request presented, waiting for mem_req_ready
// S_WAIT | request accepted, waiting for response or timeout
// S_DONE | completion pulse to WB, pipeline released
module ysyx_041461_mem_lsu #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid_in,
  input  logic [3:0]  lsu_ctrl_in,
  input  logic [63:0] lsu_addr_in,
  input  logic [63:0] lsu_wdata_in,
  input  logic        lsu_flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [7:0]  mem_req_wstrb,
  output logic [63:0] mem_req_wdata,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_rdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [63:0] lsu_rdata,
  output logic [1:0]  lsu_trap
);

  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] TO_LAST = CW'(1);

  localparam logic [1:0] TRAP_NONE  = 2'b00;
  localparam logic [1:0] TRAP_MISAL = 2'b01;
  localparam logic [1:0] TRAP_FAULT = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [63:0]    addr_q, addr_d;
  logic           wen_q, wen_d;
  logic [7:0]     wstrb_q, wstrb_d;
  logic [63:0]    wdata_q, wdata_d;
  logic [1:0]     size_q, size_d;
  logic           uns_q, uns_d;
  logic [2:0]     off_q, off_d;
  logic           killed_q, killed_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [63:0]    rdata_q, rdata_d;
  logic [1:0]     trap_q, trap_d;

  // decode of the incoming instruction
  logic           dec_load, dec_store, dec_uns;
  logic [1:0]     dec_size;
  logic           dec_misal, acc_any, acc_ok;
  logic [7:0]     dec_strb;

  always_comb begin
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_uns   = 1'b0;
    dec_size  = 2'd0;
    case (lsu_ctrl_in)
      4'b0001: begin dec_load = 1'b1; dec_size = 2'd0; end
      4'b0010: begin dec_load = 1'b1; dec_size = 2'd1; end
      4'b0011: begin dec_load = 1'b1; dec_size = 2'd2; end
      4'b0100: begin dec_load = 1'b1; dec_size = 2'd3; end
      4'b0101: begin dec_load = 1'b1; dec_size = 2'd0; dec_uns = 1'b1; end
      4'b0110: begin dec_load = 1'b1; dec_size = 2'd1; dec_uns = 1'b1; end
      4'b0111: begin dec_load = 1'b1; dec_size = 2'd2; dec_uns = 1'b1; end
      4'b1000: begin dec_store = 1'b1; dec_size = 2'd0; end
      4'b1001: begin dec_store = 1'b1; dec_size = 2'd1; end
      4'b1010: begin dec_store = 1'b1; dec_size = 2'd2; end
      4'b1011: begin dec_store = 1'b1; dec_size = 2'd3; end
      default: ;
    endcase

    case (dec_size)
      2'd1:    dec_misal = lsu_addr_in[0];
      2'd2:    dec_misal = |lsu_addr_in[1:0];
      2'd3:    dec_misal = |lsu_addr_in[2:0];
      default: dec_misal = 1'b0;
    endcase

    case (dec_size)
      2'd0:    dec_strb = 8'h01;
      2'd1:    dec_strb = 8'h03;
      2'd2:    dec_strb = 8'h0F;
      default: dec_strb = 8'hFF;
    endcase

    acc_any = lsu_valid_in && (dec_load || dec_store);
    acc_ok  = acc_any && !dec_misal;
  end

  // response lane extraction and extension
  logic [63:0] rsp_sh, rsp_ext;

  always_comb begin
    rsp_sh = mem_rsp_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    rsp_ext = uns_q ? {56'b0, rsp_sh[7:0]}  : {{56{rsp_sh[7]}},  rsp_sh[7:0]};
      2'd1:    rsp_ext = uns_q ? {48'b0, rsp_sh[15:0]} : {{48{rsp_sh[15]}}, rsp_sh[15:0]};
      2'd2:    rsp_ext = uns_q ? {32'b0, rsp_sh[31:0]} : {{32{rsp_sh[31]}}, rsp_sh[31:0]};
      default: rsp_ext = rsp_sh;
    endcase
    if (wen_q) rsp_ext = 64'b0;
  end

  logic timeout_hit;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

  // next-state
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    killed_d = killed_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    trap_d   = trap_q;

    case (state_q)
      S_IDLE: begin
        killed_d = 1'b0;
        if (acc_ok && !lsu_flush) begin
          state_d = S_REQ;
          addr_d  = {lsu_addr_in[63:3], 3'b000};
          wen_d   = dec_store;
          wstrb_d = dec_store ? (dec_strb << lsu_addr_in[2:0]) : 8'h00;
          wdata_d = dec_store ? (lsu_wdata_in << {lsu_addr_in[2:0], 3'b000}) : 64'b0;
          size_d  = dec_size;
          uns_d   = dec_uns;
          off_d   = lsu_addr_in[2:0];
        end
      end
      S_REQ: begin
        // acceptance wins over flush: the memory already owns the request
        if (mem_req_ready) begin
          state_d  = S_WAIT;
          cnt_d    = TO_LOAD;
          killed_d = lsu_flush;
        end else if (lsu_flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (lsu_flush) killed_d = 1'b1;
        if (TIMEOUT_CYC != 0) cnt_d = cnt_q - TO_LAST;
        if (mem_rsp_valid) begin
          state_d = (killed_q || lsu_flush) ? S_IDLE : S_DONE;
          rdata_d = rsp_ext;
          trap_d  = TRAP_NONE;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = (killed_q || lsu_flush) ? S_IDLE : S_DONE;
          rdata_d = 64'b0;
          trap_d  = TRAP_FAULT;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        killed_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= 64'b0;
      wen_q    <= 1'b0;
      wstrb_q  <= 8'b0;
      wdata_q  <= 64'b0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      off_q    <= 3'd0;
      killed_q <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= 64'b0;
      trap_q   <= 2'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
      killed_q <= killed_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      trap_q   <= trap_d;
    end
  end

  // outputs; the combinational ones are qualified by rst_n so that every
  // output is 0 while reset is asserted, even with an access on the inputs
  logic done_fsm, done_mis;

  always_comb begin
    done_fsm = (state_q == S_DONE) && !lsu_flush;
    done_mis = (state_q == S_IDLE) && acc_any && dec_misal && !lsu_flush;

    mem_req_valid = (state_q == S_REQ);
    mem_req_addr  = addr_q;
    mem_req_wen   = wen_q;
    mem_req_wstrb = wstrb_q;
    mem_req_wdata = wdata_q;

    lsu_stall = rst_n && acc_ok && !lsu_flush && !killed_q && (state_q != S_DONE);
    lsu_done  = rst_n && (done_fsm || done_mis);
    lsu_rdata = done_fsm ? rdata_q : 64'b0;
    if (!rst_n)        lsu_trap = TRAP_NONE;
    else if (done_fsm) lsu_trap = trap_q;
    else if (done_mis) lsu_trap = TRAP_MISAL;
    else               lsu_trap = TRAP_NONE;
  end

endmodule

// File: tb/tb_ysyx_041461_mem_lsu.sv
module tb_ysyx_041461_mem_lsu;

  logic        clk;
  logic        rst_n;
  logic        lsu_valid_in;
  logic [3:0]  lsu_ctrl_in;
  logic [63:0] lsu_addr_in;
  logic [63:0] lsu_wdata_in;
  logic        lsu_flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [7:0]  mem_req_wstrb;
  logic [63:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        lsu_stall;
  logic        lsu_done;
  logic [63:0] lsu_rdata;
  logic [1:0]  lsu_trap;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_cnt;

  ysyx_041461_mem_lsu #(.TIMEOUT_CYC(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lsu_valid_in  (lsu_valid_in),
    .lsu_ctrl_in   (lsu_ctrl_in),
    .lsu_addr_in   (lsu_addr_in),
    .lsu_wdata_in  (lsu_wdata_in),
    .lsu_flush     (lsu_flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .lsu_stall     (lsu_stall),
    .lsu_done      (lsu_done),
    .lsu_rdata     (lsu_rdata),
    .lsu_trap      (lsu_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // one cycle: inputs applied on the falling edge, outputs sampled 1ns later
  task automatic cyc(input logic v, input logic [3:0] c, input logic [63:0] a,
                     input logic [63:0] w, input logic fl, input logic rdy,
                     input logic rv, input logic [63:0] rd);
    @(negedge clk);
    lsu_valid_in  = v;
    lsu_ctrl_in   = c;
    lsu_addr_in   = a;
    lsu_wdata_in  = w;
    lsu_flush     = fl;
    mem_req_ready = rdy;
    mem_rsp_valid = rv;
    mem_rsp_rdata = rd;
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  // full load with ready on first REQ cycle and response on first WAIT cycle
  task automatic run_load(input string tag, input logic [3:0] c, input logic [63:0] a,
                          input logic [63:0] rd, input logic [63:0] exp);
    cyc(1'b1, c, a, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    cyc(1'b1, c, a, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    check_eq({tag, "_addr"}, mem_req_addr, {a[63:3], 3'b000});
    cyc(1'b1, c, a, 64'h0, 1'b0, 1'b0, 1'b1, rd);
    cyc(1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    check_eq({tag, "_done"}, 64'(lsu_done), 64'h1);
    check_eq({tag, "_rdata"}, lsu_rdata, exp);
    check_eq({tag, "_trap"}, 64'(lsu_trap), 64'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    lsu_valid_in = 1'b0; lsu_ctrl_in = 4'h0; lsu_addr_in = 64'h0; lsu_wdata_in = 64'h0;
    lsu_flush = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 64'h0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_req_valid", 64'(mem_req_valid), 64'h0);
    check_eq("rst_stall", 64'(lsu_stall), 64'h0);
    check_eq("rst_done", 64'(lsu_done), 64'h0);
    check_eq("rst_addr", mem_req_addr, 64'h0);
    check_eq("rst_rdata", lsu_rdata, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1) LW at lane 4, response on second WAIT cycle
    stall_cnt = 0;
    cyc(1'b1, 4'h3, 64'h8000_0004, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    check_eq("t1_c0_req_valid", 64'(mem_req_valid), 64'h0);
    stall_cnt += int'(lsu_stall);
    cyc(1'b1, 4'h3, 64'h8000_0004, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    check_eq("t1_req_valid", 64'(mem_req_valid), 64'h1);
    check_eq("t1_req_addr", mem_req_addr, 64'h8000_0000);
    check_eq("t1_req_wen", 64'(mem_req_wen), 64'h0);
    stall_cnt += int'(lsu_stall);
    cyc(1'b1, 4'h3, 64'h8000_0004, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    check_eq("t1_wait_req_valid", 64'(mem_req_valid), 64'h0);
    stall_cnt += int'(lsu_stall);
    cyc(1'b1, 4'h3, 64'h8000_0004, 64'h0, 1'b0, 1'b0, 1'b1, 64'h8123_4567_0000_0000);
    check_eq("t1_wait_done", 64'(lsu_done), 64'h0);
    stall_cnt += int'(lsu_stall);
    cyc(1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    stall_cnt += int'(lsu_stall);
    check_eq("t1_done", 64'(lsu_done), 64'h1);
    check_eq("t1_rdata", lsu_rdata, 64'hFFFF_FFFF_8123_4567);
    check_eq("t1_trap", 64'(lsu_trap), 64'h0);
    check_eq("t1_stall_cycles", 64'(stall_cnt), 64'd4);
    idle_cyc();
    check_eq("t1_done_one_pulse", 64'(lsu_done), 64'h0);

    // 2) SB at lane 3
    cyc(1'b1, 4'h8, 64'h8000_0003, 64'hAB, 1'b0, 1'b1, 1'b0, 64'h0);
    check_eq("t2_stall_idle", 64'(lsu_stall), 64'h1);
    cyc(1'b1, 4'h8, 64'h8000_0003, 64'hAB, 1'b0, 1'b1, 1'b0, 64'h0);
    check_eq("t2_wstrb", 64'(mem_req_wstrb), 64'h08);
    check_eq("t2_wdata", mem_req_wdata, 64'h0000_0000_AB00_0000);
    check_eq("t2_wen", 64'(mem_req_wen), 64'h1);
    check_eq("t2_addr", mem_req_addr, 64'h8000_0000);
    cyc(1'b1, 4'h8, 64'h8000_0003, 64'hAB, 1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF);
    cyc(1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    check_eq("t2_done", 64'(lsu_done), 64'h1);
    check_eq("t2_rdata_zero", lsu_rdata, 64'h0);

    // 3) misaligned LH
    cyc(1'b1, 4'h2, 64'h8000_0001, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    check_eq("t3_done", 64'(lsu_done), 64'h1);
    check_eq("t3_trap", 64'(lsu_trap), 64'h1);
    check_eq("t3_stall", 64'(lsu_stall), 64'h0);
    idle_cyc();
    check_eq("t3_no_req", 64'(mem_req_valid), 64'h0);

    // 4) SD with ready held low 5 cycles
    cyc(1'b1, 4'hB, 64'h8000_0010, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 4'hB, 64'h8000_0010, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 1'b0, 64'h0);
      check_eq("t4_req_valid", 64'(mem_req_valid), 64'h1);
      check_eq("t4_addr", mem_req_addr, 64'h8000_0010);
      check_eq("t4_wdata", mem_req_wdata, 64'h1122_3344_5566_7788);
      check_eq("t4_wstrb", 64'(mem_req_wstrb), 64'hFF);
      check_eq("t4_stall", 64'(lsu_stall), 64'h1);
    end
    cyc(1'b1, 4'hB, 64'h8000_0010, 64'h1122_3344_5566_7788, 1'b0, 1'b1, 1'b0, 64'h0);
    check_eq("t4_ready_cycle_valid", 64'(mem_req_valid), 64'h1);
    cyc(1'b1, 4'hB, 64'h8000_0010, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 1'b0, 64'h0);
    check_eq("t4_wait_valid", 64'(mem_req_valid), 64'h0);
    check_eq("t4_wait_stall", 64'(lsu_stall), 64'h1);
    cyc(1'b1, 4'hB, 64'h8000_0010, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 1'b1, 64'h0);
    cyc(1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    check_eq("t4_done", 64'(lsu_done), 64'h1);

    // load extension vectors
    run_load("lb",  4'h1, 64'h8000_0005, 64'h0000_8000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    run_load("lhu", 4'h6, 64'h8000_0006, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF);
    run_load("ld",  4'h4, 64'h8000_0008, 64'h8765_4321_0FED_CBA9, 64'h8765_4321_0FED_CBA9);
    run_load("lwu", 4'h7, 64'h8000_0000, 64'h0000_0000_F000_0001, 64'h0000_0000_F000_0001);
    run_load("lh",  4'h2, 64'h8000_0002, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);

    // 5) timeout after 4 WAIT cycles
    cyc(1'b1, 4'h5, 64'h8000_0007, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    cyc(1'b1, 4'h5, 64'h8000_0007, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 4'h5, 64'h8000_0007, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
      check_eq("t5_wait_done", 64'(lsu_done), 64'h0);
      check_eq("t5_wait_stall", 64'(lsu_stall), 64'h1);
    end
    cyc(1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    check_eq("t5_done", 64'(lsu_done), 64'h1);
    check_eq("t5_trap", 64'(lsu_trap), 64'h2);
    check_eq("t5_rdata", lsu_rdata, 64'h0);
    cyc(1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("t5_late_rsp_done", 64'(lsu_done), 64'h0);
    idle_cyc();
    check_eq("t5_late_rsp_idle", 64'(lsu_done), 64'h0);
    check_eq("t5_late_rsp_req", 64'(mem_req_valid), 64'h0);

    // 6a) flush in WAIT, then response: no done pulse
    cyc(1'b1, 4'h3, 64'h8000_0008, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    cyc(1'b1, 4'h3, 64'h8000_0008, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    cyc(1'b1, 4'h3, 64'h8000_0008, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
    check_eq("t6_flush_stall", 64'(lsu_stall), 64'h0);
    cyc(1'b1, 4'h3, 64'h8000_0008, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    check_eq("t6_killed_stall", 64'(lsu_stall), 64'h0);
    cyc(1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1, 64'h1234);
    check_eq("t6_rsp_done", 64'(lsu_done), 64'h0);
    idle_cyc();
    check_eq("t6_after_done", 64'(lsu_done), 64'h0);
    check_eq("t6_after_req", 64'(mem_req_valid), 64'h0);

    // 6b) flush in REQ without ready drops the request
    cyc(1'b1, 4'h3, 64'h8000_0020, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    cyc(1'b1, 4'h3, 64'h8000_0020, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0);
    check_eq("t6b_flush_stall", 64'(lsu_stall), 64'h0);
    idle_cyc();
    check_eq("t6b_req_dropped", 64'(mem_req_valid), 64'h0);
    check_eq("t6b_no_done", 64'(lsu_done), 64'h0);

    // 6c) reset asserted mid-REQ
    cyc(1'b1, 4'hA, 64'h8000_0044, 64'h5555, 1'b0, 1'b0, 1'b0, 64'h0);
    cyc(1'b1, 4'hA, 64'h8000_0044, 64'h5555, 1'b0, 1'b0, 1'b0, 64'h0);
    check_eq("t6c_in_req", 64'(mem_req_valid), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6c_rst_req_valid", 64'(mem_req_valid), 64'h0);
    check_eq("t6c_rst_stall", 64'(lsu_stall), 64'h0);
    check_eq("t6c_rst_addr", mem_req_addr, 64'h0);
    check_eq("t6c_rst_wdata", mem_req_wdata, 64'h0);
    check_eq("t6c_rst_wstrb", 64'(mem_req_wstrb), 64'h0);
    idle_cyc();
    rst_n = 1'b1;
    idle_cyc();
    check_eq("t6c_post_rst_req", 64'(mem_req_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
